booth_r4_seq_mul: RTL and testbench

- Iterative signed radix-4 Booth multiplier core that sits directly upstream of the team's 3:2 carry-save stage. It generates one Booth partial product per cycle and compresses it into a carry-save accumulator of width 2*LENGTH+2.
- It then resolves sum and carry with one carry-propagate add and presents a registered 2*LENGTH-bit product.
- Used where area matters more than throughput; the combinational Wallace path remains the high-throughput option.

---
 rtl/booth_r4_seq_mul.sv | 141 ++++++++++++++
 tb/tb_booth_r4_seq_mul.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mul.sv
// Iterative signed radix-4 Booth multiplier: one partial product per cycle into a
// carry-save accumulator, then a single carry-propagate add to a registered product.
module booth_r4_seq_mul #(
    parameter int unsigned LENGTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [LENGTH-1:0]     multiplicand,
    input  logic [LENGTH-1:0]     multiplier,
    output logic                  busy,
    output logic                  done,
    output logic [2*LENGTH-1:0]   product
);

    localparam int unsigned W    = 2 * LENGTH + 2;
    localparam int unsigned PW   = 2 * LENGTH;
    localparam int unsigned SW   = LENGTH + 1;
    localparam int unsigned NDIG = LENGTH / 2;
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic            accept;
    logic            last_digit;

    logic [W-1:0]    m_q;
    logic [SW-1:0]   y_q;
    logic [W-1:0]    s_q;
    logic [W-1:0]    c_q;
    logic [IW-1:0]   idx_q;

    logic [W-1:0]    m2;
    logic [W-1:0]    pp_raw;
    logic [W-1:0]    pp;
    logic [W-1:0]    s_nxt;
    logic [W-1:0]    c_nxt;
    logic [PW-1:0]   res;

    assign last_digit = (idx_q == IW'(NDIG - 1));

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (last_digit) begin
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Booth digit select, weighted partial product and 3:2 compression
    always_comb begin
        m2     = m_q << 1;
        pp_raw = '0;
        case (y_q[2:0])
            3'b001, 3'b010: pp_raw = m_q;
            3'b011:         pp_raw = m2;
            3'b100:         pp_raw = ~m2 + W'(1);
            3'b101, 3'b110: pp_raw = ~m_q + W'(1);
            default:        pp_raw = '0;
        endcase
        pp    = pp_raw << {idx_q, 1'b0};
        s_nxt = s_q ^ c_q ^ pp;
        c_nxt = ((s_q & c_q) | (s_q & pp) | (c_q & pp)) << 1;
        res   = s_q[PW-1:0] + c_q[PW-1:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        m_q   <= {{(W - LENGTH){multiplicand[LENGTH-1]}}, multiplicand};
                        y_q   <= {multiplier, 1'b0};
                        s_q   <= '0;
                        c_q   <= '0;
                        idx_q <= '0;
                        busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    s_q   <= s_nxt;
                    c_q   <= c_nxt;
                    y_q   <= y_q >> 2;
                    idx_q <= idx_q + IW'(1);
                end
                RESOLVE: begin
                    product <= res;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed and random checks for booth_r4_seq_mul at LENGTH=32.
module tb_booth_r4_seq_mul;

    localparam int unsigned LENGTH = 32;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic                 start;
    logic [LENGTH-1:0]    multiplicand;
    logic [LENGTH-1:0]    multiplier;
    logic                 busy;
    logic                 done;
    logic [2*LENGTH-1:0]  product;

    int n_checks = 0;
    int n_err    = 0;

    booth_r4_seq_mul #(.LENGTH(LENGTH)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation from accept to done; the accept edge is cycle 1
    task automatic run_op(input logic [31:0] m, input logic [31:0] y,
                          input logic [63:0] exp, input string tag, input bit pulse);
        int cyc;
        int bcnt;
        bit seen;
        bit overlap;
        multiplicand = m;
        multiplier   = y;
        start        = 1'b1;
        @(posedge sys_clk); #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        cyc     = 1;
        bcnt    = 0;
        seen    = 1'b0;
        overlap = 1'b0;
        while (cyc < 40 && !seen) begin
            if (busy && done) overlap = 1'b1;
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (pulse && (cyc == 2 || cyc == 9)) begin
                    start        = 1'b1;
                    multiplicand = 32'h0000_1234;
                    multiplier   = 32'h0000_0777;
                end else begin
                    start = 1'b0;
                end
                @(posedge sys_clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_done"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(cyc), 64'd18);
        check({tag, "_busycyc"}, 64'(bcnt), 64'd17);
        check({tag, "_overlap"}, 64'(overlap), 64'd0);
        check({tag, "_prod"}, product, exp);
        @(posedge sys_clk); #1;
        check({tag, "_donepulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, product, exp);
    endtask

    initial begin
        logic [31:0] rm;
        logic [31:0] ry;
        logic signed [63:0] rexp;
        int dcyc [3];
        int nd;
        int t;

        sys_rst_n    = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1 sys_rst_n = 1'b0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod", product, 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check("idle_busy", 64'(busy), 64'd0);

        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "m3y5", 1'b0);
        run_op(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, "m-7y6", 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "m-1y-1", 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minmin", 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "maxmin", 1'b0);
        run_op(32'd0, 32'h8765_4321, 64'd0, "m0", 1'b0);
        run_op(32'h8765_4321, 32'd0, 64'd0, "y0", 1'b0);
        run_op(32'h0000_1234, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_EDCC, "yneg1", 1'b0);
        run_op(32'd12, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFD0, "ignore", 1'b1);

        // start held high: results must arrive every 18 cycles
        multiplicand = 32'd5;
        multiplier   = 32'hFFFF_FFFD;
        start        = 1'b1;
        nd = 0;
        t  = 0;
        while (t < 80 && nd < 3) begin
            @(posedge sys_clk); #1;
            t++;
            if (done) begin
                check("held_prod", product, 64'hFFFF_FFFF_FFFF_FFF1);
                dcyc[nd] = t;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held_count", 64'(nd), 64'd3);
        if (nd == 3) begin
            check("held_gap1", 64'(dcyc[1] - dcyc[0]), 64'd18);
            check("held_gap2", 64'(dcyc[2] - dcyc[1]), 64'd18);
        end
        @(posedge sys_clk); #1;

        // asynchronous reset in the middle of an operation
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge sys_clk); #1;
        end
        check("pre_rst_busy", 64'(busy), 64'd1);
        #1 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_prod", product, 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check("post_rst_done", 64'(done), 64'd0);
        run_op(32'd2, 32'd2, 64'd4, "m2y2", 1'b0);

        for (int k = 0; k < 1000; k++) begin
            rm   = $urandom;
            ry   = $urandom;
            rexp = $signed({{32{rm[31]}}, rm}) * $signed({{32{ry[31]}}, ry});
            run_op(rm, ry, rexp, "rand", 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
